mem_resp_ctrl: RTL and testbench
================================

# mem_resp_ctrl

Wait-state memory responder serving the cache/TLB side of the physical memory bus (`mem_a`, `mem_st_data`, `mem_access`, `mem_write`, `mem_data`, `mem_ready`).

- Accepts one word read or write at a time and holds it for a programmable latency.
- Commits writes to, or reads from, an internal word RAM, then pulses `mem_ready` for one cycle.
- It is the responder end of the bus the CPU's cache controller initiates on, and drops in as the main-memory model in CPU/cache testbenches.

## Interface
- `ADDR_W`, default 10: word-index width; RAM depth is 2^ADDR_W words.
- `LATENCY`, default 4: cycles from request acceptance to `mem_ready`; legal values are 1..15.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `mem_a` in 32: byte address; word index = `mem_a[ADDR_W+1:2]`; `mem_a[1:0]` ignored.
- `mem_st_data` in 32: write data.
- `mem_access` in 1: request valid.
- `mem_write` in 1: 1 = write, 0 = read; qualified by `mem_access`.
- `mem_data` out 32: read data, valid while `mem_ready`=1.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_err` out 1: sticky out-of-range flag; tied 0 unless `MEM_RANGE_CHECK_EN` is defined.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- **IDLE:**
  - If `mem_access`=1 at the rising edge, the request is accepted.
  - `mem_a`, `mem_write` and `mem_st_data` are latched into internal registers.
  - Down-counter loads LATENCY-1.
  - Next state is RESP if LATENCY=1, otherwise WAIT.
- **WAIT:**
  - Counter decrements each edge.
  - Moves to RESP on the edge where the counter is 1 (before it decrements to 0).
  - Bus inputs are ignored; only latched values are used, so address or data changes mid-request have no effect.
- **Entering RESP:**
  - On the same edge, a write updates RAM at the latched index.
  - On the same edge, a read loads `mem_data` from RAM at the latched index.
  - `mem_ready` registers to 1.
- **RESP:**
  - `mem_ready`=1 for exactly this cycle.
  - `mem_access` is ignored, because the initiator still holds it while consuming the response.
  - Next state is always IDLE.
- `mem_data` holds its last read value until the next read completes; writes do not change `mem_data`.
- A read issued after a write completes returns the new data; there is no read-after-write hazard.
- RAM contents are not cleared by reset and power up as X. The bench preloads them through hierarchical access or a write sequence.

## Timing
- Request accepted at edge E0 → `mem_ready` high during cycle E0+LATENCY → back in IDLE at edge E0+LATENCY+1.
- Minimum request-to-request spacing is LATENCY+1 cycles. A request held high through the cycle after RESP is accepted as a new request.
- Reset values: state IDLE, `mem_ready`=0, `mem_data`=32'h0, `mem_err`=0, counter 0.
- Reset during WAIT or RESP:
  - Request is abandoned and state returns to IDLE.
  - No RAM write occurs unless RESP entry had already happened.
  - `mem_ready` is 0 in the cycle after the reset edge.
- `mem_ready` is a registered output: no combinational path from any input.

## Configuration
- Macro: `MEM_RANGE_CHECK_EN`.
- **Defined:**
  - A request with `mem_a[31:ADDR_W+2]` ≠ 0 is out of range.
  - Out-of-range writes are dropped.
  - Out-of-range reads return 32'hDEADBEEF.
  - `mem_err` sets at RESP entry and stays set until reset.
  - Latency and handshake are unchanged.
- **Undefined:**
  - Upper address bits are ignored, so addresses alias modulo 2^(ADDR_W+2) bytes.
  - `mem_err` is constant 0.

## Test plan
- **Reset/idle:** assert `reset` 2 cycles with `mem_access`=1 → `mem_ready`=0 and `mem_data`=0 throughout; the first request is accepted on the first edge after `reset` falls.
- **Write then read, LATENCY=4:**
  - Write 32'h12345678 to `mem_a`=32'h40 → `mem_ready` pulses exactly 4 cycles after acceptance, width 1.
  - Read 32'h40 → `mem_data`=32'h12345678 in the ready cycle.
- **Input churn:** change `mem_a` to 32'h80 and `mem_st_data` during WAIT of a write to 32'h44 → RAM[0x44>>2] holds the original data; word 0x80 is unchanged.
- **Back-to-back:** hold `mem_access`=1 continuously over 3 reads → `mem_ready` pulses every LATENCY+1 cycles; each pulse returns data for the address presented at its acceptance edge.
- **Reset mid-request:** assert `reset` in WAIT of a write of 32'hCAFEF00D to 32'h10 → no `mem_ready`; a later read of 32'h10 returns the prior value.
- **Range check (`MEM_RANGE_CHECK_EN`, ADDR_W=10):**
  - Read 32'h00001000 → 32'hDEADBEEF and `mem_err`=1, staying 1 across subsequent in-range accesses.
  - Without the macro, the same read returns RAM word 0.

Source files
------------

// File: rtl/mem_resp_ctrl.sv
// Wait-state word-RAM responder: latches one request, waits LATENCY cycles, then pulses mem_ready.
// Optional feature macro: MEM_RANGE_CHECK_EN (out-of-range detect, sticky mem_err).
module mem_resp_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_a,
  input  logic [31:0] mem_st_data,
  input  logic        mem_access,
  input  logic        mem_write,
  output logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        wr_q, wr_d, ready_q, ready_d;

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  logic              resp_entry, ram_we;
  logic [31:0]       req_a, req_wdata;
  logic              req_wr, req_oor;
  logic [ADDR_W-1:0] req_idx;
  logic              unused_bits;

  // With LATENCY=1 the response is entered on the accept edge, so the live bus
  // values stand in for the not-yet-latched ones.
  always_comb begin
    req_a      = (state_q == IDLE) ? mem_a       : addr_q;
    req_wdata  = (state_q == IDLE) ? mem_st_data : wdata_q;
    req_wr     = (state_q == IDLE) ? mem_write   : wr_q;
    req_idx    = req_a[ADDR_W+1:2];
`ifdef MEM_RANGE_CHECK_EN
    req_oor    = |req_a[31:ADDR_W+2];
`else
    req_oor    = 1'b0;
`endif
    resp_entry = ((state_q == IDLE) && mem_access && (LATENCY == 1)) ||
                 ((state_q == WAIT) && (cnt_q == 4'd1));
    ram_we     = resp_entry && req_wr && !req_oor && !reset;
  end

  assign unused_bits = ^{req_a[1:0], req_a[31:ADDR_W+2]};

  // State and request registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: if (mem_access) begin
        addr_d  = mem_a;
        wdata_d = mem_st_data;
        wr_d    = mem_write;
        cnt_d   = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = resp_entry;
    rdata_d = rdata_q;
    if (resp_entry && !req_wr)
      rdata_d = req_oor ? 32'hDEAD_BEEF : ram[req_idx];
  end

  // RAM has no reset; contents survive reset and power up undefined.
  always_ff @(posedge clock) begin
    if (ram_we) ram[req_idx] <= req_wdata;
  end

  assign mem_ready = ready_q;
  assign mem_data  = rdata_q;

`ifdef MEM_RANGE_CHECK_EN
  logic err_q, err_d;
  always_comb err_d = err_q | (resp_entry & req_oor);
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Self-checking bench for mem_resp_ctrl: directed table, corner sequences and
// random traffic checked every cycle against a transaction-level model.
module tb_mem_resp_ctrl;
  localparam int AW   = 10;
  localparam int L    = 4;
  localparam int NPRE = 36;

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [31:0] RANGE_RD_EXP = 32'hDEAD_BEEF;
  localparam logic [31:0] ERR_EXP      = 32'h1;
`else
  localparam logic [31:0] RANGE_RD_EXP = 32'h5A00_0000;  // word 0 preload value
  localparam logic [31:0] ERR_EXP      = 32'h0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_a = 32'h0, mem_st_data = 32'h0;
  logic        mem_access = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_data;
  logic        mem_ready, mem_err;

  int vectors = 0, miscompares = 0;

  mem_resp_ctrl #(.ADDR_W(AW), .LATENCY(L)) dut (
    .clock(clock), .reset(reset), .mem_a(mem_a), .mem_st_data(mem_st_data),
    .mem_access(mem_access), .mem_write(mem_write),
    .mem_data(mem_data), .mem_ready(mem_ready), .mem_err(mem_err));

  always #5 clock = ~clock;

  // Reference model: a request is taken when the responder is free; it completes
  // LATENCY-1 edges later and the responder is free again two edges after that.
  logic [31:0] m_ram   [0:(1<<AW)-1];
  bit          m_known [0:(1<<AW)-1];
  int          e = 0, free_at = 0, due = 0;
  bit          pend = 0, p_wr = 0;
  logic [31:0] p_a = 0, p_d = 0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_rd_known = 1, m_ready = 0, m_err = 0;

  function automatic logic [31:0] pre(int i);
    return 32'h5A00_0000 ^ 32'(i * 32'h0001_0203);
  endfunction

  function automatic bit is_oor(logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
    return a[31:AW+2] != 0;
`else
    return a == 32'hFFFF_FFFF && 1'b0;
`endif
  endfunction

  task automatic model_step(bit rst, bit acc, bit wr, logic [31:0] a, logic [31:0] d);
    int idx;
    e++;
    m_ready = 0;
    if (rst) begin
      pend = 0; m_rdata = 32'h0; m_rd_known = 1; m_err = 0; free_at = e + 1;
      return;
    end
    if (!pend && acc && e >= free_at) begin
      pend = 1; p_wr = wr; p_a = a; p_d = d; due = e + L - 1; free_at = e + L + 1;
    end
    if (pend && e == due) begin
      pend = 0; m_ready = 1;
      idx = int'(p_a[AW+1:2]);
      if (is_oor(p_a)) begin
        m_err = 1;
        if (!p_wr) begin m_rdata = 32'hDEAD_BEEF; m_rd_known = 1; end
      end else if (p_wr) begin
        m_ram[idx] = p_d; m_known[idx] = 1;
      end else begin
        m_rdata = m_ram[idx]; m_rd_known = m_known[idx];
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    bit rst, acc, wr;
    logic [31:0] a, d;
    rst = reset; acc = mem_access; wr = mem_write; a = mem_a; d = mem_st_data;
    @(posedge clock);
    model_step(rst, acc, wr, a, d);
    #1;
    chk("model ready", {31'h0, mem_ready}, {31'h0, m_ready});
    chk("model err",   {31'h0, mem_err},   {31'h0, m_err});
    if (m_rd_known) chk("model data", mem_data, m_rdata);
  endtask

  // Request already accepted on the last tick; wait for the pulse, then return to IDLE.
  task automatic wait_ready(string name, bit chk_data, logic [31:0] exp);
    int lat = 1;
    while (!mem_ready && lat < 40) begin tick(); lat++; end
    chk({name, " latency"}, 32'(lat), 32'(L));
    if (chk_data) chk({name, " data"}, mem_data, exp);
    tick();
  endtask

  task automatic do_req(bit wr, logic [31:0] a, logic [31:0] d, string name,
                        bit chk_data, logic [31:0] exp);
    mem_access = 1; mem_write = wr; mem_a = a; mem_st_data = d;
    tick();
    mem_access = 0;
    wait_ready(name, chk_data, exp);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          rd_chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];
  logic [31:0] bb_a [3];
  logic [31:0] bb_exp [3];

  initial begin
    tbl[0] = '{1, 32'h0000_0040, 32'h1234_5678, 0, 32'h0};
    tbl[1] = '{0, 32'h0000_0040, 32'h0,         1, 32'h1234_5678};
    tbl[2] = '{1, 32'h0000_0103, 32'h0BAD_F00D, 0, 32'h0};
    tbl[3] = '{0, 32'h0000_0100, 32'h0,         1, 32'h0BAD_F00D};
    tbl[4] = '{1, 32'h0000_0FFC, 32'hFFFF_FFFF, 0, 32'h0};
    tbl[5] = '{0, 32'h0000_0FFE, 32'h0,         1, 32'hFFFF_FFFF};
    tbl[6] = '{0, 32'h0000_0008, 32'h0,         1, 32'h5A02_0406};
    tbl[7] = '{0, 32'h0000_0040, 32'h0,         1, 32'h1234_5678};
    bb_a[0] = 32'h0C; bb_a[1] = 32'h14; bb_a[2] = 32'h1C;
    bb_exp[0] = pre(3); bb_exp[1] = pre(5); bb_exp[2] = pre(7);

    // Reset with a request pending on the bus
    reset = 1; mem_access = 1; mem_write = 1; mem_a = 32'h0; mem_st_data = pre(0);
    repeat (2) begin
      tick();
      chk("reset ready", {31'h0, mem_ready}, 32'h0);
      chk("reset data",  mem_data, 32'h0);
    end
    reset = 0;
    do_req(1, 32'h0, pre(0), "first after reset", 0, 32'h0);

    for (int i = 1; i < NPRE; i++) do_req(1, 32'(i * 4), pre(i), "preload", 0, 32'h0);

    for (int i = 0; i < 8; i++)
      do_req(tbl[i].wr, tbl[i].a, tbl[i].d, $sformatf("tbl%0d", i), tbl[i].rd_chk, tbl[i].exp);

    // Bus churn during WAIT must not affect the latched write
    mem_access = 1; mem_write = 1; mem_a = 32'h44; mem_st_data = 32'hAAAA_1111;
    tick();
    mem_access = 0; mem_a = 32'h80; mem_st_data = 32'hBBBB_2222;
    wait_ready("churn wr", 0, 32'h0);
    do_req(0, 32'h44, 32'h0, "churn rd44", 1, 32'hAAAA_1111);
    do_req(0, 32'h80, 32'h0, "churn rd80", 1, pre(32));

    // Back-to-back reads with mem_access held high
    begin
      int pulses = 0;
      mem_access = 1; mem_write = 0; mem_a = bb_a[0];
      for (int k = 0; k < 3 * (L + 1); k++) begin
        tick();
        if (k % (L + 1) == 0) begin
          if (k / (L + 1) < 2) mem_a = bb_a[k / (L + 1) + 1];
          else mem_access = 0;
        end
        if (k % (L + 1) == L - 1) begin
          chk("b2b ready", {31'h0, mem_ready}, 32'h1);
          if (mem_ready) begin
            chk("b2b data", mem_data, bb_exp[k / (L + 1)]);
            pulses++;
          end
        end
      end
      chk("b2b pulses", 32'(pulses), 32'd3);
    end

    // Reset during WAIT abandons the write
    mem_access = 1; mem_write = 1; mem_a = 32'h10; mem_st_data = 32'hCAFE_F00D;
    tick();
    mem_access = 0;
    tick();
    reset = 1;
    tick();
    chk("midrst ready", {31'h0, mem_ready}, 32'h0);
    reset = 0;
    repeat (L + 1) begin
      tick();
      chk("midrst no ready", {31'h0, mem_ready}, 32'h0);
    end
    do_req(0, 32'h10, 32'h0, "midrst rd", 1, pre(4));

    // Out-of-range read (or alias of word 0 when the check is compiled out)
    do_req(0, 32'h0000_1000, 32'h0, "range rd", 1, RANGE_RD_EXP);
    do_req(0, 32'h0000_0008, 32'h0, "range next", 1, pre(2));
    chk("err sticky", {31'h0, mem_err}, ERR_EXP);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int unsigned idx;
      logic [31:0] up;
      reset      = ($urandom % 150) == 0;
      mem_access = ($urandom % 3) != 0;
      mem_write  = $urandom % 2;
      idx        = $urandom % NPRE;
      up         = (($urandom % 8) == 0) ? ($urandom & 32'hFFFF_F000) : 32'h0;
      mem_a      = up | (idx << 2) | ($urandom % 4);
      mem_st_data = $urandom;
      tick();
    end
    reset = 0; mem_access = 0;
    repeat (L + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
